// File: rtl/ws2812_pkg.sv
// Shared constants, FSM state type and pixel reordering helper for the WS2812 frame feeder.
package ws2812_pkg;

   localparam int unsigned LED_NUM_DEFAULT = 64;
   localparam int unsigned BITS_PER_LED    = 24;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StShift,
      StDone
   } fsm_state_e;

   // Host pixels arrive as {R,G,B}; the LED wire order is {G,R,B}.
   function automatic logic [BITS_PER_LED-1:0] rgb_to_grb(input logic [BITS_PER_LED-1:0] rgb);
      return {rgb[15:8], rgb[23:16], rgb[7:0]};
   endfunction

endpackage

// File: rtl/ws2812_frame_feeder_if.sv
// Host write port plus serializer bit handshake of the WS2812 frame feeder.
interface ws2812_frame_feeder_if #(
   parameter int unsigned LED_NUM = ws2812_pkg::LED_NUM_DEFAULT
) ();
   import ws2812_pkg::*;

   localparam int unsigned AW = $clog2(LED_NUM);

   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic [BITS_PER_LED-1:0] wr_data;
   logic                    frame_start;
   logic                    bit_req;
   logic                    bit_out;
   logic                    bit_valid;
   logic                    busy;
   logic                    frame_done;

   // Host / serializer side
   modport master (
      output wr_en, wr_addr, wr_data, frame_start, bit_req,
      input  bit_out, bit_valid, busy, frame_done
   );

   // Feeder side
   modport slave (
      input  wr_en, wr_addr, wr_data, frame_start, bit_req,
      output bit_out, bit_valid, busy, frame_done
   );

endinterface

// File: rtl/ws2812_pixel_ram.sv
// Double-buffered pixel store: writes go to the back bank, a registered read port serves the
// front bank selected by i_bank_sel.
module ws2812_pixel_ram
   import ws2812_pkg::*;
#(
   parameter int unsigned LED_NUM = LED_NUM_DEFAULT,
   localparam int unsigned AW = $clog2(LED_NUM)
) (
   input  logic                    i_clk,
   input  logic                    i_bank_sel,
   input  logic                    i_wr_en,
   input  logic [AW-1:0]           i_wr_addr,
   input  logic [BITS_PER_LED-1:0] i_wr_data,
   input  logic [AW-1:0]           i_rd_addr,
   output logic [BITS_PER_LED-1:0] o_rd_data
);

   logic [BITS_PER_LED-1:0] r_bank0 [LED_NUM];
   logic [BITS_PER_LED-1:0] r_bank1 [LED_NUM];
   logic                    w_wr_ok;

   // Out-of-range addresses only exist when LED_NUM is not a power of two.
   assign w_wr_ok = i_wr_en && (32'(i_wr_addr) < LED_NUM);

   // Bank 0 is the back bank while bank 1 is in front.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok && i_bank_sel) begin
         r_bank0[i_wr_addr] <= i_wr_data;
      end
   end

   // Bank 1 is the back bank while bank 0 is in front.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok && !i_bank_sel) begin
         r_bank1[i_wr_addr] <= i_wr_data;
      end
   end

   // Synchronous read of the front bank.
   always_ff @(posedge i_clk) begin
      o_rd_data <= i_bank_sel ? r_bank1[i_rd_addr] : r_bank0[i_rd_addr];
   end

endmodule

// File: rtl/ws2812_frame_feeder.sv
// Streams a double-buffered frame of GRB pixels, MSB first, one bit per serializer request.
module ws2812_frame_feeder
   import ws2812_pkg::*;
#(
   parameter int unsigned LED_NUM = LED_NUM_DEFAULT
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   ws2812_frame_feeder_if.slave  io_bus
);

   localparam int unsigned     AW      = $clog2(LED_NUM);
   localparam logic [AW-1:0]   LastPix = AW'(LED_NUM - 1);
   localparam logic [4:0]      LastBit = 5'(BITS_PER_LED - 1);

   fsm_state_e              r_state;
   logic                    r_bank_sel;
   logic [AW-1:0]           r_pix_idx;
   logic [4:0]              r_bit_cnt;
   logic [BITS_PER_LED-1:0] r_shreg;
   logic [BITS_PER_LED-1:0] r_prefetch;
   logic                    r_bit_valid;
   logic                    r_busy;
   logic                    r_frame_done;
   logic                    r_fetch_rdy;
   logic [AW-1:0]           w_rd_addr;
   logic [BITS_PER_LED-1:0] w_rd_data;

   // FETCH reads pixel 0; afterwards the read port tracks the pixel after the one shifting.
   always_comb begin
      w_rd_addr = '0;
      if (r_state != StFetch && r_pix_idx != LastPix) begin
         w_rd_addr = r_pix_idx + AW'(1);
      end
   end

   ws2812_pixel_ram #(
      .LED_NUM (LED_NUM)
   ) u_ram (
      .i_clk      (i_sys_clk),
      .i_bank_sel (r_bank_sel),
      .i_wr_en    (io_bus.wr_en),
      .i_wr_addr  (io_bus.wr_addr),
      .i_wr_data  (io_bus.wr_data),
      .i_rd_addr  (w_rd_addr),
      .o_rd_data  (w_rd_data)
   );

   // Prefetch the next pixel while the current one shifts; the front bank is stable mid-frame.
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         r_prefetch <= '0;
      end else if (r_state == StShift) begin
         r_prefetch <= w_rd_data;
      end
   end

   // Frame sequencing, bit shifting and registered status outputs.
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         r_state      <= StIdle;
         r_bank_sel   <= 1'b0;
         r_pix_idx    <= '0;
         r_bit_cnt    <= '0;
         r_shreg      <= '0;
         r_bit_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_fetch_rdy  <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io_bus.frame_start) begin
                  r_bank_sel  <= ~r_bank_sel;
                  r_pix_idx   <= '0;
                  r_busy      <= 1'b1;
                  r_fetch_rdy <= 1'b0;
                  r_state     <= StFetch;
               end
            end
            StFetch: begin
               // First cycle issues the read of pixel 0, second consumes its data.
               if (!r_fetch_rdy) begin
                  r_fetch_rdy <= 1'b1;
               end else begin
                  r_shreg     <= rgb_to_grb(w_rd_data);
                  r_bit_cnt   <= '0;
                  r_bit_valid <= 1'b1;
                  r_state     <= StShift;
               end
            end
            StShift: begin
               if (io_bus.bit_req && r_bit_valid) begin
                  if (r_bit_cnt != LastBit) begin
                     r_shreg   <= {r_shreg[BITS_PER_LED-2:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end else if (r_pix_idx != LastPix) begin
                     r_shreg   <= rgb_to_grb(r_prefetch);
                     r_bit_cnt <= '0;
                     r_pix_idx <= r_pix_idx + AW'(1);
                  end else begin
                     r_shreg     <= '0;
                     r_bit_valid <= 1'b0;
                     r_state     <= StDone;
                  end
               end
            end
            StDone: begin
               // Pulse frame_done, then drop busy one cycle later so a restart cannot race it.
               if (!r_frame_done) begin
                  r_frame_done <= 1'b1;
               end else begin
                  r_frame_done <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign io_bus.bit_out    = r_shreg[BITS_PER_LED-1];
   assign io_bus.bit_valid  = r_bit_valid;
   assign io_bus.busy       = r_busy;
   assign io_bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Directed bench for ws2812_frame_feeder with a bit-level scoreboard and a bank model.
module tb_ws2812_frame_feeder;
   import ws2812_pkg::*;

   localparam int unsigned N  = 2;
   localparam int unsigned AW = $clog2(N);
   localparam int unsigned NB = N * BITS_PER_LED;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ws2812_frame_feeder_if #(.LED_NUM(N)) bus ();

   ws2812_frame_feeder #(
      .LED_NUM (N)
   ) dut (
      .i_sys_clk (clk),
      .i_sys_rst (rst),
      .io_bus    (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   bit          exp_q[$];
   logic [23:0] m_bank [2][N];
   bit          m_sel = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push the whole front frame of the model, GRB and MSB first.
   task automatic push_frame();
      logic [23:0] g;
      for (int p = 0; p < int'(N); p++) begin
         g = rgb_to_grb(m_bank[m_sel][p]);
         for (int i = 23; i >= 0; i--) exp_q.push_back(g[i]);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic write_px(input int a, input logic [23:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = d;
      m_bank[~m_sel][a] = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic start_frame(input bit do_wr, input logic [23:0] d, input bit chk);
      bus.frame_start = 1'b1;
      if (do_wr) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = '0;
         bus.wr_data = d;
         m_bank[~m_sel][0] = d;
      end
      m_sel = ~m_sel;
      if (chk) push_frame();
      @(negedge clk);
      bus.frame_start = 1'b0;
      bus.wr_en       = 1'b0;
      check("busy_after_e0", bus.busy, 1);
      check("valid_after_e0", bus.bit_valid, 0);
      @(negedge clk);
      check("valid_after_e1", bus.bit_valid, 0);
      @(negedge clk);
      check("valid_after_e2", bus.bit_valid, 1);
   endtask

   task automatic stream(input int gap, input int nbits, input int wr_at,
                         input logic [23:0] wr_d, input bit try_restart, input bit chk);
      for (int b = 0; b < nbits; b++) begin
         if (gap > 1) begin
            bus.bit_req = 1'b0;
            repeat (gap - 1) @(negedge clk);
         end
         check("valid_in_frame", bus.bit_valid, 1);
         if (chk) check($sformatf("bit%0d", b), bus.bit_out, exp_q.pop_front());
         bus.bit_req = 1'b1;
         if (try_restart) bus.frame_start = 1'b1;
         if (b == wr_at) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = '0;
            bus.wr_data = wr_d;
            m_bank[~m_sel][0] = wr_d;
         end
         @(negedge clk);
         bus.frame_start = 1'b0;
         bus.wr_en       = 1'b0;
      end
   endtask

   task automatic finish_frame(input bit hold_req, input bit restart);
      bus.bit_req = hold_req;
      check("valid_drop", bus.bit_valid, 0);
      check("bit_out_idle", bus.bit_out, 0);
      check("done_not_yet", bus.frame_done, 0);
      check("busy_at_e", bus.busy, 1);
      check("sb_drained", exp_q.size(), 0);
      @(negedge clk);
      check("done_pulse", bus.frame_done, 1);
      check("busy_at_e1", bus.busy, 1);
      bus.frame_start = restart;
      @(negedge clk);
      bus.frame_start = 1'b0;
      check("done_single", bus.frame_done, 0);
      check("busy_clear", bus.busy, 0);
      repeat (3) begin
         @(negedge clk);
         check("idle_busy", bus.busy, 0);
         check("idle_valid", bus.bit_valid, 0);
         check("idle_done", bus.frame_done, 0);
      end
      bus.bit_req = 1'b0;
   endtask

   initial begin
      bus.wr_en       = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.frame_start = 1'b0;
      bus.bit_req     = 1'b1;

      // Reset values, with stray bit_req that must be ignored.
      repeat (3) @(negedge clk);
      check("rst_bit_out", bus.bit_out, 0);
      check("rst_valid", bus.bit_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.frame_done, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_req_valid", bus.bit_valid, 0);
      check("idle_req_busy", bus.busy, 0);
      bus.bit_req = 1'b0;

      // Frame with unwritten RAM: timing and bit count only.
      start_frame(1'b0, '0, 1'b0);
      stream(1, NB, -1, '0, 1'b0, 1'b0);
      finish_frame(1'b0, 1'b0);

      // Bit order across a pixel boundary, back-to-back requests.
      write_px(0, 24'h12_34_56);
      write_px(1, 24'hFF_00_81);
      start_frame(1'b0, '0, 1'b1);
      stream(1, NB, -1, '0, 1'b0, 1'b1);
      finish_frame(1'b0, 1'b0);

      // Fill the other bank, then write the back bank mid-frame.
      write_px(0, 24'h0F_1E_2D);
      write_px(1, 24'h3C_4B_5A);
      start_frame(1'b0, '0, 1'b1);
      stream(1, NB, 10, 24'hAA_AA_AA, 1'b0, 1'b1);
      finish_frame(1'b0, 1'b0);

      // Alternation: the mid-frame write shows up once its bank is in front.
      start_frame(1'b0, '0, 1'b1);
      stream(3, NB, -1, '0, 1'b0, 1'b1);
      finish_frame(1'b1, 1'b0);

      // Sparse requests with frame_start hammered while busy.
      start_frame(1'b0, '0, 1'b1);
      stream(55, NB, -1, '0, 1'b1, 1'b1);
      finish_frame(1'b0, 1'b1);

      // Write in the same cycle as frame_start is part of this frame.
      start_frame(1'b1, 24'h00_80_00, 1'b1);
      stream(1, NB, -1, '0, 1'b0, 1'b1);
      finish_frame(1'b0, 1'b0);

      // Reset at pixel 1, bit 5.
      start_frame(1'b0, '0, 1'b1);
      stream(1, BITS_PER_LED + 5, -1, '0, 1'b0, 1'b1);
      bus.bit_req = 1'b0;
      check("pre_rst_valid", bus.bit_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("abort_bit_out", bus.bit_out, 0);
      check("abort_valid", bus.bit_valid, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_bank_sel", dut.r_bank_sel, 0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", bus.frame_done, 0);
      end
      rst = 1'b0;
      exp_q.delete();
      m_sel = 1'b0;
      @(negedge clk);
      check("post_rst_done", bus.frame_done, 0);
      check("post_rst_busy", bus.busy, 0);

      // Restart after reset transmits bank 1 from pixel 0.
      start_frame(1'b0, '0, 1'b1);
      stream(1, NB, -1, '0, 1'b0, 1'b1);
      finish_frame(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
